// File: rtl/cpu_switch_pio_edge.sv
// Avalon-MM read/IRQ slave for switches and buttons: synchronise, debounce,
// capture selected edges into a sticky W1C register and raise a masked level IRQ.
module cpu_switch_pio_edge #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] stable_bus;
  logic [WIDTH-1:0] stable_bus_next;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] wr_bits;
  logic             wr_en;
  logic [31:0]      readdata_next;
  logic             irq_next;

  // Input synchroniser: plain shift chain per bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= '0;
      end
    end else begin
      sync_reg[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             bit_stable_reg;
      logic             bit_stable_next;

      // Any agreeing cycle drops the count, so short glitches never reach stable
      always_comb begin
        cnt_next        = '0;
        bit_stable_next = bit_stable_reg;
        if (sync_out[gi] != bit_stable_reg) begin
          if (cnt_reg == CNT_LAST) begin
            bit_stable_next = sync_out[gi];
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg        <= '0;
          bit_stable_reg <= 1'b0;
        end else begin
          cnt_reg        <= cnt_next;
          bit_stable_reg <= bit_stable_next;
        end
      end

      assign stable_bus[gi]      = bit_stable_reg;
      assign stable_bus_next[gi] = bit_stable_next;
    end
  endgenerate

  // Edge is flagged on the same clock that the stable value changes
  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign edge_set = stable_bus_next & ~stable_bus;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign edge_set = ~stable_bus_next & stable_bus;
    end else begin : g_both
      assign edge_set = stable_bus_next ^ stable_bus;
    end
  endgenerate

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    mask_next = mask_reg;
    edge_clr  = '0;
    if (wr_en && address == ADDR_MASK) begin
      mask_next = wr_bits;
    end
    if (wr_en && address == ADDR_EDGE) begin
      edge_clr = wr_bits;
    end
    // A fresh capture outranks a simultaneous clear
    edge_next = (edge_reg & ~edge_clr) | edge_set;
  end

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA: readdata_next = 32'(stable_bus);
      ADDR_RAW:  readdata_next = 32'(sync_out);
      ADDR_MASK: readdata_next = 32'(mask_reg);
      ADDR_EDGE: readdata_next = 32'(edge_reg);
      default:   readdata_next = '0;
    endcase
    irq_next = |(edge_reg & mask_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
      edge_reg <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      mask_reg <= mask_next;
      edge_reg <= edge_next;
      readdata <= readdata_next;
      irq      <= irq_next;
    end
  end

endmodule

// File: tb/tb_cpu_switch_pio_edge.sv
// Scoreboard bench: a rising-edge and a falling-edge instance share stimulus and
// are compared against a run-length model of synchroniser, debounce and edge capture.
module tb_cpu_switch_pio_edge;

  localparam int W  = 10;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_port    = '0;
  logic          rd_en      = 1'b0;
  logic [31:0]   rd0, rd1;
  logic          irq0, irq1;

  always #5 clk = ~clk;

  cpu_switch_pio_edge #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  cpu_switch_pio_edge #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  typedef struct {
    logic [1:0]  a;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        i0;
    logic        i1;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn_no   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference model state
  logic [W-1:0] m_pipe [SS];
  logic [W-1:0] m_stable;
  int           m_run [W];
  logic [W-1:0] m_mask;
  logic [W-1:0] m_edge [2];

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_pipe[s] = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
    m_stable = '0;
    m_mask   = '0;
    m_edge[0] = '0;
    m_edge[1] = '0;
    sb.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] sync_now, old_stable, new_stable, clr, set_r, set_f;
    txn_t t;
    logic [31:0] rdv [2];
    logic        irqv [2];
    sync_now   = m_pipe[SS-1];
    old_stable = m_stable;
    new_stable = m_stable;
    // A bit flips once sync has disagreed with it for DC consecutive clocks
    for (int b = 0; b < W; b++) begin
      if (sync_now[b] != old_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          new_stable[b] = sync_now[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      case (address)
        2'd0:    rdv[k] = 32'(old_stable);
        2'd1:    rdv[k] = 32'(sync_now);
        2'd2:    rdv[k] = 32'(m_mask);
        default: rdv[k] = 32'(m_edge[k]);
      endcase
      irqv[k] = |(m_edge[k] & m_mask);
    end
    clr   = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    set_r = new_stable & ~old_stable;
    set_f = old_stable & ~new_stable;
    m_edge[0] = (m_edge[0] & ~clr) | set_r;
    m_edge[1] = (m_edge[1] & ~clr) | set_f;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_stable = new_stable;
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = in_port;
    if (rd_en) begin
      t.a  = address;
      t.e0 = rdv[0];
      t.e1 = rdv[1];
      t.i0 = irqv[0];
      t.i1 = irqv[1];
      sb.push_back(t);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Monitor: readdata/irq are presented every clock; compare queued reads on the far edge
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        t = sb.pop_front();
        txn_no++;
        $display("txn %0d addr=%0d rd0=%h exp=%h rd1=%h exp=%h irq=%b%b exp=%b%b",
                 txn_no, t.a, rd0, t.e0, rd1, t.e1, irq0, irq1, t.i0, t.i1);
        chk("sb_rd0", rd0, t.e0);
        chk("sb_rd1", rd1, t.e1);
        chk("sb_irq0", 32'(irq0), 32'(t.i0));
        chk("sb_irq1", 32'(irq1), 32'(t.i1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    rd_en = 1'b1;
    tick(2);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_irq0", 32'(irq0), 32'h0);
    reset_n = 1'b1;

    // Reset state on every register
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick(1);
      chk("s1_rd0", rd0, 32'h0);
      chk("s1_rd1", rd1, 32'h0);
    end
    chk("s1_irq0", 32'(irq0), 32'h0);

    // Step latency through RAW and DATA
    address = 2'd1;
    in_port = 10'h155;
    tick(2);
    chk("s2_raw_2", rd0, 32'h0);
    tick(1);
    chk("s2_raw_3", rd0, 32'h155);
    address = 2'd0;
    tick(3);
    chk("s2_data_6", rd0, 32'h0);
    tick(1);
    chk("s2_data_7", rd0, 32'h155);
    in_port = '0;
    tick(8);
    bus_write(2'd3, 32'h3FF);
    address = 2'd3;
    tick(1);
    chk("s2_edge_clr0", rd0, 32'h0);
    chk("s2_edge_clr1", rd1, 32'h0);

    // Short pulse must be rejected
    in_port = 10'h001;
    tick(3);
    in_port = '0;
    tick(10);
    address = 2'd0;
    tick(1);
    chk("s3_data", rd0, 32'h0);
    address = 2'd3;
    tick(1);
    chk("s3_edge0", rd0, 32'h0);
    chk("s3_edge1", rd1, 32'h0);

    // Masked capture, IRQ and W1C
    bus_write(2'd2, 32'h001);
    in_port = 10'h001;
    address = 2'd3;
    tick(8);
    chk("s4_edge", rd0, 32'h1);
    chk("s4_irq", 32'(irq0), 32'h1);
    bus_write(2'd3, 32'h1);
    address = 2'd3;
    tick(1);
    chk("s4_edge_w1c", rd0, 32'h0);
    chk("s4_irq_w1c", 32'(irq0), 32'h0);
    in_port = '0;
    tick(8);
    chk("s4_fall_irq1", 32'(irq1), 32'h1);
    chk("s4_fall_irq0", 32'(irq0), 32'h0);
    bus_write(2'd3, 32'h3FF);

    // Falling-edge instance ignores rising transitions
    bus_write(2'd2, 32'h3FF);
    in_port = 10'h3FF;
    tick(8);
    address = 2'd3;
    tick(1);
    chk("s5_rise_edge1", rd1, 32'h0);
    chk("s5_rise_edge0", rd0, 32'h3FF);
    in_port = '0;
    tick(8);
    chk("s5_fall_edge1", rd1, 32'h3FF);
    chk("s5_fall_irq1", 32'(irq1), 32'h1);
    bus_write(2'd3, 32'h3FF);
    tick(2);

    // W1C landing on the capture edge loses to the set
    in_port = 10'h001;
    tick(5);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'h1;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick(1);
    chk("s6_set_wins0", rd0, 32'h1);
    chk("s6_set_wins1", rd1, 32'h0);

    // Asynchronous reset in the middle of a debounce count
    in_port = '0;
    tick(3);
    reset_n = 1'b0;
    #1;
    chk("s6_async_rd0", rd0, 32'h0);
    chk("s6_async_rd1", rd1, 32'h0);
    chk("s6_async_irq0", 32'(irq0), 32'h0);
    chk("s6_async_irq1", 32'(irq1), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      rd_en   = 1'($urandom_range(0, 1));
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      writedata = $urandom;
      if ($urandom_range(0, 6) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
      end
      tick(1);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd_en      = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
